// File: rtl/rs_csr_inorder_if.sv
// rtl/rs_csr_inorder_if.sv - dispatch/wakeup/flush/issue bundle for the CSR reservation station
//
// Purpose: groups every non-clock, non-reset signal of rs_csr_inorder.
// Ports (signals):
//   dispatch : start, RS_inst_num, Rd, ALUOP, csr_data, operand1, operand1_valid
//   wakeup   : wb_valid[NUM_WB], wb_tag[NUM_WB*TAG_W] (channel c at [c*TAG_W +: TAG_W])
//   flush    : flush_valid, flush_inst_num
//   issue    : issue_ready (in), issue_valid and issue_* payload (out)
//   status   : full, count
// Modports: master drives the station (dispatch/wakeup/flush/issue_ready),
//           slave is the station itself.
interface rs_csr_inorder_if #(
   parameter int DEPTH  = 16,
   parameter int TAG_W  = 8,
   parameter int NUM_WB = 6,
   parameter int INST_W = 32,
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
);
   logic                      start;
   logic [INST_W-1:0]         RS_inst_num;
   logic [TAG_W-1:0]          Rd;
   logic [OP_W-1:0]           ALUOP;
   logic [DATA_W-1:0]         csr_data;
   logic [TAG_W-1:0]          operand1;
   logic                      operand1_valid;

   logic [NUM_WB-1:0]         wb_valid;
   logic [NUM_WB*TAG_W-1:0]   wb_tag;

   logic                      flush_valid;
   logic [INST_W-1:0]         flush_inst_num;

   logic                      issue_ready;
   logic                      issue_valid;
   logic [TAG_W-1:0]          issue_operand1;
   logic [INST_W-1:0]         issue_inst_num;
   logic [TAG_W-1:0]          issue_Rd;
   logic [OP_W-1:0]           issue_ALUOP;
   logic [DATA_W-1:0]         issue_csr_data;

   logic                      full;
   logic [$clog2(DEPTH+1)-1:0] count;

   modport master (
      output start, RS_inst_num, Rd, ALUOP, csr_data, operand1, operand1_valid,
      output wb_valid, wb_tag, flush_valid, flush_inst_num, issue_ready,
      input  issue_valid, issue_operand1, issue_inst_num, issue_Rd, issue_ALUOP,
      input  issue_csr_data, full, count
   );

   modport slave (
      input  start, RS_inst_num, Rd, ALUOP, csr_data, operand1, operand1_valid,
      input  wb_valid, wb_tag, flush_valid, flush_inst_num, issue_ready,
      output issue_valid, issue_operand1, issue_inst_num, issue_Rd, issue_ALUOP,
      output issue_csr_data, full, count
   );
endinterface

// File: rtl/rs_csr_inorder.sv
// rtl/rs_csr_inorder.sv - in-order CSR reservation station with wakeup, flush and issue register
//
// Purpose: holds dispatched CSR ops in a program-order circular queue, wakes their
// single source tag from NUM_WB broadcast channels, and issues only the oldest
// entry (once ready) through a valid/ready issue register. Mispredict flush kills
// every entry younger than flush_inst_num.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high
//   bus   - rs_csr_inorder_if.slave: dispatch, wakeup, flush, issue handshake, full/count
module rs_csr_inorder #(
   parameter int DEPTH  = 16,
   parameter int TAG_W  = 8,
   parameter int NUM_WB = 6,
   parameter int INST_W = 32,
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input logic             clk,
   input logic             reset,
   rs_csr_inorder_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   // Entry payload (no reset needed: occ_q qualifies every use)
   logic [INST_W-1:0] inst_q [DEPTH];
   logic [TAG_W-1:0]  rd_q   [DEPTH];
   logic [OP_W-1:0]   op_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [TAG_W-1:0]  src_q  [DEPTH];

   logic [DEPTH-1:0]  occ_q, occ_d;
   logic [DEPTH-1:0]  rdy_q, rdy_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;

   logic              issue_valid_q, issue_valid_d;
   logic [TAG_W-1:0]  issue_src_q;
   logic [INST_W-1:0] issue_inst_q;
   logic [TAG_W-1:0]  issue_rd_q;
   logic [OP_W-1:0]   issue_op_q;
   logic [DATA_W-1:0] issue_data_q;

   logic [DEPTH-1:0]  kill;
   logic [DEPTH-1:0]  wake;
   logic [CNT_W-1:0]  survivors;
   logic              head_ok;
   logic              load;
   logic              accept;
   logic              disp_rdy;
   logic              issue_kill;

   function automatic logic wb_match(
      input logic [TAG_W-1:0]        tag,
      input logic [NUM_WB-1:0]       valid,
      input logic [NUM_WB*TAG_W-1:0] tags
   );
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < NUM_WB; c++) begin
         if (valid[c] && (tags[c*TAG_W +: TAG_W] == tag)) hit = 1'b1;
      end
      return hit;
   endfunction

   // Per-entry flush kill and wakeup match. Occupied entries are contiguous
   // from head in program order, so the killed ones form a suffix and the
   // survivor count alone locates the new tail.
   always_comb begin
      kill      = '0;
      wake      = '0;
      survivors = '0;
      for (int i = 0; i < DEPTH; i++) begin
         kill[i] = bus.flush_valid && occ_q[i] && (inst_q[i] > bus.flush_inst_num);
         wake[i] = wb_match(src_q[i], bus.wb_valid, bus.wb_tag);
         if (occ_q[i] && !kill[i]) survivors = survivors + CNT_W'(1);
      end
   end

   assign head_ok    = occ_q[head_q] && rdy_q[head_q] && !kill[head_q];
   assign load       = head_ok && (!issue_valid_q || bus.issue_ready);
   // full is registered, so a dispatch against a full queue is dropped even
   // if the head pops in the same cycle.
   assign accept     = bus.start && !full_q && !bus.flush_valid;
   // Same-cycle bypass: a broadcast coinciding with dispatch marks it ready.
   assign disp_rdy   = bus.operand1_valid || wb_match(bus.operand1, bus.wb_valid, bus.wb_tag);
   assign issue_kill = bus.flush_valid && issue_valid_q && (issue_inst_q > bus.flush_inst_num);

   always_comb begin
      occ_d         = occ_q;
      rdy_d         = rdy_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      issue_valid_d = issue_valid_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (occ_q[i] && wake[i]) rdy_d[i] = 1'b1;
      end

      if (load) begin
         occ_d[head_q] = 1'b0;
         rdy_d[head_q] = 1'b0;
         head_d        = head_q + PTR_W'(1);
      end

      if (bus.flush_valid) begin
         occ_d   = occ_d & ~kill;
         rdy_d   = rdy_d & ~kill;
         tail_d  = head_q + survivors[PTR_W-1:0];
         count_d = survivors - CNT_W'(load);
      end else begin
         if (accept) begin
            occ_d[tail_q] = 1'b1;
            rdy_d[tail_q] = disp_rdy;
            tail_d        = tail_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(accept) - CNT_W'(load);
      end

      // A load always carries a surviving op, so it wins over a flush kill.
      if (load) begin
         issue_valid_d = 1'b1;
      end else if (issue_kill || (issue_valid_q && bus.issue_ready)) begin
         issue_valid_d = 1'b0;
      end
   end

   assign full_d = (count_d == CNT_W'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q         <= '0;
         rdy_q         <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         full_q        <= 1'b0;
         issue_valid_q <= 1'b0;
         issue_src_q   <= '0;
         issue_inst_q  <= '0;
         issue_rd_q    <= '0;
         issue_op_q    <= '0;
         issue_data_q  <= '0;
      end else begin
         occ_q         <= occ_d;
         rdy_q         <= rdy_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         full_q        <= full_d;
         issue_valid_q <= issue_valid_d;
         // Payload only changes on a load, which keeps it stable under backpressure.
         if (load) begin
            issue_src_q  <= src_q[head_q];
            issue_inst_q <= inst_q[head_q];
            issue_rd_q   <= rd_q[head_q];
            issue_op_q   <= op_q[head_q];
            issue_data_q <= data_q[head_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         inst_q[tail_q] <= bus.RS_inst_num;
         rd_q[tail_q]   <= bus.Rd;
         op_q[tail_q]   <= bus.ALUOP;
         data_q[tail_q] <= bus.csr_data;
         src_q[tail_q]  <= bus.operand1;
      end
   end

   assign bus.full           = full_q;
   assign bus.count          = count_q;
   assign bus.issue_valid    = issue_valid_q;
   assign bus.issue_operand1 = issue_src_q;
   assign bus.issue_inst_num = issue_inst_q;
   assign bus.issue_Rd       = issue_rd_q;
   assign bus.issue_ALUOP    = issue_op_q;
   assign bus.issue_csr_data = issue_data_q;
endmodule

// File: tb/tb_rs_csr_inorder.sv
// tb/tb_rs_csr_inorder.sv - directed self-checking bench for rs_csr_inorder
module tb_rs_csr_inorder;
   logic clk;
   logic reset;

   rs_csr_inorder_if #(
      .DEPTH(16), .TAG_W(8), .NUM_WB(6), .INST_W(32), .DATA_W(32), .OP_W(4)
   ) bus ();

   rs_csr_inorder #(
      .DEPTH(16), .TAG_W(8), .NUM_WB(6), .INST_W(32), .DATA_W(32), .OP_W(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int got_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start          = 1'b0;
      bus.RS_inst_num    = '0;
      bus.Rd             = '0;
      bus.ALUOP          = '0;
      bus.csr_data       = '0;
      bus.operand1       = '0;
      bus.operand1_valid = 1'b0;
      bus.wb_valid       = '0;
      bus.wb_tag         = '0;
      bus.flush_valid    = 1'b0;
      bus.flush_inst_num = '0;
   endtask

   task automatic drive_disp(input logic [31:0] inst, input logic [7:0] src, input logic src_v);
      bus.start          = 1'b1;
      bus.RS_inst_num    = inst;
      bus.Rd             = inst[7:0];
      bus.ALUOP          = inst[3:0];
      bus.csr_data       = inst ^ 32'hA5A5_0000;
      bus.operand1       = src;
      bus.operand1_valid = src_v;
   endtask

   task automatic wb(input int ch, input logic [7:0] tag);
      bus.wb_valid[ch]        = 1'b1;
      bus.wb_tag[ch*8 +: 8]   = tag;
   endtask

   // Records the op present in each cycle where the handshake completes at the next edge.
   task automatic collect(input int n);
      for (int k = 0; k < n; k++) begin
         if (bus.issue_valid && bus.issue_ready) got_q.push_back(int'(bus.issue_inst_num));
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0;
      reset = 1'b1;
      idle_inputs();
      bus.issue_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_count", bus.count, 0);
      check("rst_full", bus.full, 0);
      check("rst_valid", bus.issue_valid, 0);
      check("rst_inst", bus.issue_inst_num, 0);
      check("rst_rd", bus.issue_Rd, 0);

      // 16 ready dispatches, output free: issue from the 3rd cycle, one per cycle
      bus.issue_ready = 1'b1;
      for (int cyc = 1; cyc <= 19; cyc++) begin
         if (cyc <= 16) drive_disp(cyc, 8'h01, 1'b1);
         else idle_inputs();
         tick();
         check($sformatf("t1_valid_c%0d", cyc), bus.issue_valid, (cyc >= 2 && cyc <= 17));
         if (cyc >= 2 && cyc <= 17) check($sformatf("t1_inst_c%0d", cyc), bus.issue_inst_num, cyc - 1);
         check($sformatf("t1_full_c%0d", cyc), bus.full, 0);
      end

      // Fill to full with unready ops, 17th dropped, then release
      bus.issue_ready = 1'b0;
      for (int k = 0; k < 17; k++) begin
         drive_disp(101 + k, 8'h55, 1'b0);
         tick();
         if (k == 14) begin
            check("t2_count15", bus.count, 15);
            check("t2_full15", bus.full, 0);
         end
         if (k == 15) begin
            check("t2_count16", bus.count, 16);
            check("t2_full16", bus.full, 1);
         end
      end
      idle_inputs();
      check("t2_count_after17", bus.count, 16);
      check("t2_full_after17", bus.full, 1);
      check("t2_held_valid", bus.issue_valid, 0);
      wb(2, 8'h55);
      bus.issue_ready = 1'b1;
      tick();
      idle_inputs();
      got_q.delete();
      collect(20);
      check("t2_n", got_q.size(), 16);
      for (int k = 0; k < 16 && k < got_q.size(); k++) check($sformatf("t2_ord%0d", k), got_q[k], 101 + k);
      check("t2_drained", bus.count, 0);

      // Unready head blocks a ready younger entry until its wakeup
      drive_disp(201, 8'h21, 1'b0);
      tick();
      drive_disp(202, 8'h30, 1'b1);
      tick();
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("t3_blocked%0d", k), bus.issue_valid, 0);
      end
      check("t3_count", bus.count, 2);
      wb(3, 8'h21);
      tick();
      idle_inputs();
      check("t3_t1", bus.issue_valid, 0);
      tick();
      check("t3_t2_valid", bus.issue_valid, 1);
      check("t3_t2_inst", bus.issue_inst_num, 201);
      tick();
      check("t3_t3_valid", bus.issue_valid, 1);
      check("t3_t3_inst", bus.issue_inst_num, 202);
      tick();
      check("t3_done", bus.issue_valid, 0);

      // Same-cycle bypass at dispatch, plus payload fields
      drive_disp(301, 8'h40, 1'b0);
      wb(0, 8'h40);
      tick();
      idle_inputs();
      check("t4_t1", bus.issue_valid, 0);
      tick();
      check("t4_valid", bus.issue_valid, 1);
      check("t4_inst", bus.issue_inst_num, 301);
      check("t4_rd", bus.issue_Rd, 8'h2D);
      check("t4_op", bus.issue_ALUOP, 4'hD);
      check("t4_data", bus.issue_csr_data, 32'hA5A5_012D);
      check("t4_src", bus.issue_operand1, 8'h40);
      tick();
      check("t4_done", bus.issue_valid, 0);

      // Selective flush: issue holds 4, queue 5..10, flush >7
      bus.issue_ready = 1'b0;
      for (int k = 4; k <= 10; k++) begin
         drive_disp(k, 8'h10, 1'b1);
         tick();
      end
      idle_inputs();
      check("t5_pre_count", bus.count, 6);
      check("t5_pre_inst", bus.issue_inst_num, 4);
      bus.flush_valid    = 1'b1;
      bus.flush_inst_num = 7;
      drive_disp(99, 8'h10, 1'b1);
      tick();
      idle_inputs();
      check("t5_count", bus.count, 3);
      check("t5_full", bus.full, 0);
      check("t5_held_valid", bus.issue_valid, 1);
      check("t5_held_inst", bus.issue_inst_num, 4);
      drive_disp(8, 8'h10, 1'b1);
      tick();
      idle_inputs();
      check("t5_redisp_count", bus.count, 4);
      bus.issue_ready = 1'b1;
      got_q.delete();
      collect(8);
      check("t5_n", got_q.size(), 5);
      for (int k = 0; k < 5 && k < got_q.size(); k++) check($sformatf("t5_ord%0d", k), got_q[k], 4 + k);

      // Flush that kills the issue register itself
      bus.issue_ready = 1'b0;
      drive_disp(20, 8'h10, 1'b1);
      tick();
      drive_disp(21, 8'h10, 1'b1);
      tick();
      idle_inputs();
      check("t6_pre_inst", bus.issue_inst_num, 20);
      check("t6_pre_count", bus.count, 1);
      bus.flush_valid    = 1'b1;
      bus.flush_inst_num = 19;
      tick();
      idle_inputs();
      check("t6_valid", bus.issue_valid, 0);
      check("t6_count", bus.count, 0);

      // Fill 12, drain 12 (pointers wrap), refill 10, reset mid-drain
      for (int k = 0; k < 12; k++) begin
         drive_disp(401 + k, 8'h66, 1'b0);
         tick();
      end
      idle_inputs();
      check("t7_count12", bus.count, 12);
      wb(5, 8'h66);
      tick();
      idle_inputs();
      bus.issue_ready = 1'b1;
      got_q.delete();
      collect(16);
      check("t7_n", got_q.size(), 12);
      for (int k = 0; k < 12 && k < got_q.size(); k++) check($sformatf("t7_ord%0d", k), got_q[k], 401 + k);
      bus.issue_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         drive_disp(501 + k, 8'h77, 1'b0);
         tick();
      end
      idle_inputs();
      check("t7_count10", bus.count, 10);
      wb(1, 8'h77);
      tick();
      idle_inputs();
      bus.issue_ready = 1'b1;
      got_q.delete();
      collect(4);
      check("t7_part_n", got_q.size(), 3);
      for (int k = 0; k < 3 && k < got_q.size(); k++) check($sformatf("t7_part%0d", k), got_q[k], 501 + k);
      reset = 1'b1;
      drive_disp(700, 8'h01, 1'b1);
      tick();
      reset = 1'b0;
      idle_inputs();
      check("t7_rst_valid", bus.issue_valid, 0);
      check("t7_rst_count", bus.count, 0);
      check("t7_rst_full", bus.full, 0);
      check("t7_rst_inst", bus.issue_inst_num, 0);
      drive_disp(600, 8'h01, 1'b1);
      tick();
      idle_inputs();
      check("t7_post_t1", bus.issue_valid, 0);
      tick();
      check("t7_post_valid", bus.issue_valid, 1);
      check("t7_post_inst", bus.issue_inst_num, 600);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
